// File: rtl/rev_band_classifier_pkg.sv
// Shared band / ignition types and the threshold classifier for rev_band_classifier.
package rev_pkg;

    typedef logic [1:0] band_t;

    localparam band_t BAND_IDLE = 2'b00;
    localparam band_t BAND_LOW  = 2'b01;
    localparam band_t BAND_MID  = 2'b10;
    localparam band_t BAND_HIGH = 2'b11;

    typedef enum logic {
        IGN_OFF = 1'b0,
        IGN_ON  = 1'b1
    } ign_state_t;

    // Highest band whose threshold n reaches; also used with the lowered hysteresis thresholds.
    function automatic band_t classify(input int n, input int th1, input int th2, input int th3);
        if (n >= th3) return BAND_HIGH;
        if (n >= th2) return BAND_MID;
        if (n >= th1) return BAND_LOW;
        return BAND_IDLE;
    endfunction

endpackage

// File: rtl/rev_band_classifier_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus a stable-level counter; level_o changes only
// after the synced input has differed from it for DEB_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic level_o
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [DW-1:0] deb_q, deb_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            deb_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            deb_q   <= deb_d;
        end
    end

    always_comb begin
        level_d = level_q;
        deb_d   = '0;
        if (sync2_q != level_q) begin
            if (deb_q == DW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/rev_band_classifier.sv
// rev_band_classifier: debounced ignition toggle (A) and windowed tach-pulse band (C).
// Define REV_BAND_HYST_EN to enable downward hysteresis; otherwise C follows the raw band.
module rev_band_classifier
    import rev_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int CNT_W         = 8,
    parameter int TH1           = 10,
    parameter int TH2           = 20,
    parameter int TH3           = 40,
    parameter int HYST          = 2,
    parameter int DEB_CYCLES    = 16
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  tach_in,
    input  logic  ign_btn,
    output band_t C,
    output logic  A,
    output logic  c_valid
);

`ifdef REV_BAND_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;

    ign_state_t       ign_q, ign_d;
    logic             run_q, run_d;
    logic             btn_lvl, btn_prev_q;
    logic             tach_s1_q, tach_s2_q, tach_prev_q;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    band_t            band_q, band_d;
    logic             valid_q, valid_d;

    logic             press;
    logic             tach_edge;
    logic             win_end;
    logic [CNT_W-1:0] n_cnt;
    band_t            up_band;
    band_t            new_band;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) return v + 1'b1;
        return v;
    endfunction

    // Rising is immediate; falling needs n to drop below the lowered thresholds.
    function automatic band_t hyst_band(input band_t up, input int n, input band_t b);
        band_t dn;
        if (up > b) return up;
        dn = classify(n, TH1 - HYST, TH2 - HYST, TH3 - HYST);
        return (dn < b) ? dn : b;
    endfunction

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_ign_deb (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_i  (ign_btn),
        .level_o(btn_lvl)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ign_q       <= IGN_OFF;
            run_q       <= 1'b0;
            btn_prev_q  <= 1'b0;
            tach_s1_q   <= 1'b0;
            tach_s2_q   <= 1'b0;
            tach_prev_q <= 1'b0;
            win_q       <= '0;
            cnt_q       <= '0;
            band_q      <= BAND_IDLE;
            valid_q     <= 1'b0;
        end else begin
            ign_q       <= ign_d;
            run_q       <= run_d;
            btn_prev_q  <= btn_lvl;
            tach_s1_q   <= tach_in;
            tach_s2_q   <= tach_s1_q;
            tach_prev_q <= tach_s2_q;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            band_q      <= band_d;
            valid_q     <= valid_d;
        end
    end

    assign press     = btn_lvl & ~btn_prev_q;
    assign tach_edge = tach_s2_q & ~tach_prev_q;
    assign win_end   = (win_q == WIN_W'(WINDOW_CYCLES - 1));
    assign n_cnt     = sat_inc(cnt_q, tach_edge);
    assign up_band   = classify(int'(n_cnt), TH1, TH2, TH3);
    assign new_band  = HYST_EN ? hyst_band(up_band, int'(n_cnt), band_q) : up_band;

    // run_q delays measurement by one cycle after A rises, so the window starts fresh.
    always_comb begin
        ign_d   = ign_q;
        run_d   = run_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        band_d  = band_q;
        valid_d = 1'b0;
        case (ign_q)
            IGN_OFF: begin
                run_d = 1'b0;
                win_d = '0;
                cnt_d = '0;
                if (press) ign_d = IGN_ON;
            end
            IGN_ON: begin
                if (press) begin
                    ign_d  = IGN_OFF;
                    run_d  = 1'b0;
                    win_d  = '0;
                    cnt_d  = '0;
                    band_d = BAND_IDLE;
                end else begin
                    run_d = 1'b1;
                    if (run_q) begin
                        if (win_end) begin
                            win_d   = '0;
                            cnt_d   = '0;
                            band_d  = new_band;
                            valid_d = 1'b1;
                        end else begin
                            win_d = win_q + 1'b1;
                            cnt_d = n_cnt;
                        end
                    end
                end
            end
            default: ign_d = IGN_OFF;
        endcase
    end

    assign C       = band_q;
    assign A       = (ign_q == IGN_ON);
    assign c_valid = valid_q;

endmodule
